// File: rtl/restoration_sequencer.sv
// Frame sequencer for the dehaze restoration datapath: issues pixel operands,
// tracks the one-stage datapath result and frames the output stream.
module restoration_sequencer #(
    parameter int NPIX_W = 20,
    parameter int T_W    = 11,
    parameter int T_MAX  = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NPIX_W-1:0] cfg_npix,
    input  logic [7:0]        cfg_ar,
    input  logic [7:0]        cfg_ag,
    input  logic [7:0]        cfg_ab,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_r,
    input  logic [7:0]        s_g,
    input  logic [7:0]        s_b,
    input  logic [T_W-1:0]    s_t,
    output logic [7:0]        dp_er,
    output logic [7:0]        dp_eg,
    output logic [7:0]        dp_eb,
    output logic [T_W-1:0]    dp_t,
    output logic [7:0]        dp_ar,
    output logic [7:0]        dp_ag,
    output logic [7:0]        dp_ab,
    input  logic [8:0]        dp_r,
    input  logic [8:0]        dp_g,
    input  logic [8:0]        dp_b,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [8:0]        m_r,
    output logic [8:0]        m_g,
    output logic [8:0]        m_b,
    output logic              m_last,
    output logic              busy,
    output logic              frame_done,
    output logic              start_err
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [NPIX_W-1:0] npix_q, cnt_q;
    logic              vld_q, last_q, err_q;
    logic [7:0]        ar_q, ag_q, ab_q;
    logic [7:0]        er_q, eg_q, eb_q;
    logic [T_W-1:0]    t_q;

    logic              issue, accept, is_last;
    logic [T_W-1:0]    t_clamp_d;

    assign s_ready   = (state_q == STREAM) && (!vld_q || m_ready);
    assign issue     = s_valid && s_ready;
    assign accept    = vld_q && m_ready;
    assign is_last   = (cnt_q == npix_q - NPIX_W'(1));
    assign t_clamp_d = (s_t > T_W'(T_MAX)) ? T_W'(T_MAX) : s_t;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            npix_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            ar_q    <= '0;
            ag_q    <= '0;
            ab_q    <= '0;
            er_q    <= '0;
            eg_q    <= '0;
            eb_q    <= '0;
            t_q     <= '0;
        end else begin
            err_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                vld_q   <= 1'b0;
                last_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        if (cfg_npix != '0) begin
                            npix_q  <= cfg_npix;
                            ar_q    <= cfg_ar;
                            ag_q    <= cfg_ag;
                            ab_q    <= cfg_ab;
                            cnt_q   <= '0;
                            last_q  <= 1'b0;
                            state_q <= STREAM;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    STREAM: begin
                        // Operands only move on issue so a stalled result is recomputed unchanged.
                        if (issue) begin
                            er_q   <= s_r;
                            eg_q   <= s_g;
                            eb_q   <= s_b;
                            t_q    <= t_clamp_d;
                            vld_q  <= 1'b1;
                            last_q <= is_last;
                            cnt_q  <= cnt_q + NPIX_W'(1);
                            if (is_last) state_q <= DRAIN;
                        end else if (accept) begin
                            vld_q <= 1'b0;
                        end
                    end
                    DRAIN: if (accept) begin
                        vld_q <= 1'b0;
                        if (last_q) state_q <= DONE;
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign dp_er      = er_q;
    assign dp_eg      = eg_q;
    assign dp_eb      = eb_q;
    assign dp_t       = t_q;
    assign dp_ar      = ar_q;
    assign dp_ag      = ag_q;
    assign dp_ab      = ab_q;
    assign m_valid    = vld_q;
    assign m_last     = vld_q && last_q;
    assign m_r        = dp_r;
    assign m_g        = dp_g;
    assign m_b        = dp_b;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign start_err  = err_q;

endmodule

// File: tb/tb_restoration_sequencer.sv
// Bench for restoration_sequencer: transaction-level model plus directed
// scenarios, then randomized traffic with aborts and back-pressure.
module tb_restoration_sequencer;

    localparam int TMAX = 255;

    logic        i_clk, i_rst, start, abort, s_valid, m_ready;
    logic [19:0] cfg_npix;
    logic [7:0]  cfg_ar, cfg_ag, cfg_ab, s_r, s_g, s_b;
    logic [10:0] s_t, dp_t;
    logic        s_ready, m_valid, m_last, busy, frame_done, start_err;
    logic [7:0]  dp_er, dp_eg, dp_eb, dp_ar, dp_ag, dp_ab;
    logic [8:0]  dp_r, dp_g, dp_b, m_r, m_g, m_b;

    int total = 0;
    int bad   = 0;

    restoration_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst), .start(start), .abort(abort),
        .cfg_npix(cfg_npix), .cfg_ar(cfg_ar), .cfg_ag(cfg_ag), .cfg_ab(cfg_ab),
        .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b), .s_t(s_t),
        .dp_er(dp_er), .dp_eg(dp_eg), .dp_eb(dp_eb), .dp_t(dp_t),
        .dp_ar(dp_ar), .dp_ag(dp_ag), .dp_ab(dp_ab),
        .dp_r(dp_r), .dp_g(dp_g), .dp_b(dp_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_r(m_r), .m_g(m_g), .m_b(m_b),
        .m_last(m_last), .busy(busy), .frame_done(frame_done), .start_err(start_err)
    );

    // Stand-in restoration datapath: any function of the held operands will do.
    function automatic logic [8:0] dpf(input logic [7:0] e, input logic [7:0] a, input logic [10:0] t);
        int s;
        s = int'(e) * 3 + int'(a) + int'(t);
        return 9'(s % 512);
    endfunction

    assign dp_r = dpf(dp_er, dp_ar, dp_t);
    assign dp_g = dpf(dp_eg, dp_ag, dp_t);
    assign dp_b = dpf(dp_eb, dp_ab, dp_t);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Model: frame bookkeeping in plain integers.
    bit   m_act, m_done, m_err, m_pv, m_pl;
    int   m_n, m_cnt;
    logic [7:0]  m_er, m_eg, m_eb, m_ar, m_ag, m_ab;
    logic [10:0] m_t;

    function automatic bit mdl_sready();
        return m_act && (m_cnt < m_n) && (!m_pv || m_ready);
    endfunction

    task automatic model_reset();
        m_act = 0; m_done = 0; m_err = 0; m_pv = 0; m_pl = 0;
        m_n = 0; m_cnt = 0;
        m_er = 0; m_eg = 0; m_eb = 0; m_ar = 0; m_ag = 0; m_ab = 0; m_t = 0;
    endtask

    task automatic model_tick();
        bit iss, acc, fin;
        if (!i_rst) begin
            model_reset();
            return;
        end
        iss = s_valid && mdl_sready();
        acc = m_pv && m_ready;
        fin = m_act && (m_cnt == m_n) && acc && m_pl;
        m_err = 0;
        if (abort) begin
            m_act = 0; m_done = 0; m_pv = 0; m_pl = 0; m_cnt = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_act) begin
            if (start) begin
                if (cfg_npix == 0) m_err = 1;
                else begin
                    m_n = int'(cfg_npix); m_cnt = 0; m_pl = 0; m_act = 1;
                    m_ar = cfg_ar; m_ag = cfg_ag; m_ab = cfg_ab;
                end
            end
        end else if (iss) begin
            m_er = s_r; m_eg = s_g; m_eb = s_b;
            m_t  = (int'(s_t) > TMAX) ? 11'(TMAX) : s_t;
            m_pl = (m_cnt == m_n - 1);
            m_cnt++;
            m_pv = 1;
        end else if (acc) begin
            m_pv = 0;
            if (fin) begin m_act = 0; m_done = 1; end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("s_ready",    32'(s_ready),    32'(mdl_sready()));
        chk("m_valid",    32'(m_valid),    32'(m_pv));
        chk("m_last",     32'(m_last),     32'(m_pv && m_pl));
        chk("busy",       32'(busy),       32'(m_act || m_done));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("start_err",  32'(start_err),  32'(m_err));
        chk("dp_er", 32'(dp_er), 32'(m_er));
        chk("dp_eg", 32'(dp_eg), 32'(m_eg));
        chk("dp_eb", 32'(dp_eb), 32'(m_eb));
        chk("dp_t",  32'(dp_t),  32'(m_t));
        chk("dp_ar", 32'(dp_ar), 32'(m_ar));
        chk("dp_ag", 32'(dp_ag), 32'(m_ag));
        chk("dp_ab", 32'(dp_ab), 32'(m_ab));
        chk("m_r", 32'(m_r), 32'(dpf(m_er, m_ar, m_t)));
        chk("m_g", 32'(m_g), 32'(dpf(m_eg, m_ag, m_t)));
        chk("m_b", 32'(m_b), 32'(dpf(m_eb, m_ab, m_t)));
    endtask

    task automatic step();
        @(posedge i_clk);
        model_tick();
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic rnd_pix();
        s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
        s_t = ($urandom % 2 == 0) ? 11'($urandom_range(0, 255)) : 11'($urandom);
    endtask

    task automatic go_idle();
        start = 0; s_valid = 0; m_ready = 1; abort = 1;
        step();
        abort = 0;
    endtask

    task automatic begin_frame(input int n);
        start = 1; cfg_npix = 20'(n);
        step();
        start = 0;
    endtask

    initial begin
        int nv, first_v, last_c, fd_c;
        logic [8:0] exp0;
        i_rst = 0; start = 0; abort = 0; s_valid = 0; m_ready = 0;
        cfg_npix = 0; cfg_ar = 0; cfg_ag = 0; cfg_ab = 0;
        s_r = 0; s_g = 0; s_b = 0; s_t = 0;
        model_reset();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        step();
        i_rst = 1;
        step();

        // Nominal 4-pixel frame, no back-pressure.
        cfg_ar = 200; cfg_ag = 180; cfg_ab = 160;
        s_valid = 1; m_ready = 1; rnd_pix();
        begin_frame(4);
        chk("latched_ar", 32'(dp_ar), 200);
        chk("latched_ab", 32'(dp_ab), 160);
        nv = 0; first_v = -1; last_c = -1; fd_c = -1;
        for (int i = 0; i < 8; i++) begin
            rnd_pix();
            step();
            if (m_valid) begin nv++; if (first_v < 0) first_v = i; end
            if (m_last) last_c = i;
            if (frame_done) fd_c = i;
        end
        chk("nom_outputs", 32'(nv), 4);
        chk("nom_first", 32'(first_v), 0);
        chk("nom_last_at", 32'(last_c), 3);
        chk("nom_done_at", 32'(fd_c), 4);
        chk("nom_busy_end", 32'(busy), 0);

        // Transmission clamp.
        go_idle();
        s_valid = 0;
        begin_frame(2);
        s_valid = 1; s_t = 11'd2047;
        step();
        chk("clamp_2047", 32'(dp_t), 255);
        s_t = 11'd100;
        step();
        chk("clamp_100", 32'(dp_t), 100);
        s_valid = 0;
        repeat (4) step();

        // Downstream stall of five cycles after the first output.
        go_idle();
        cfg_ar = 10; cfg_ag = 20; cfg_ab = 30;
        s_valid = 1; m_ready = 1;
        s_r = 8'd50; s_g = 8'd60; s_b = 8'd70; s_t = 11'd300;
        begin_frame(4);
        step();
        exp0 = 9'((50 * 3 + 10 + 255) % 512);
        m_ready = 0;
        s_r = 8'd91; s_g = 8'd92; s_b = 8'd93; s_t = 11'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_s_ready", 32'(s_ready), 0);
            chk("stall_m_r", 32'(m_r), 32'(exp0));
            chk("stall_dp_er", 32'(dp_er), 50);
        end
        m_ready = 1;
        step();
        chk("release_next", 32'(m_r), 32'((91 * 3 + 10 + 7) % 512));
        repeat (6) begin rnd_pix(); step(); end

        // Zero-length start and start while busy.
        go_idle();
        s_valid = 0;
        begin_frame(0);
        chk("zero_err", 32'(start_err), 1);
        chk("zero_busy", 32'(busy), 0);
        step();
        chk("zero_err_clr", 32'(start_err), 0);
        begin_frame(3);
        start = 1; cfg_npix = 0;
        step();
        start = 0;
        chk("busy_start_ignored", 32'(start_err), 0);
        chk("busy_still", 32'(busy), 1);
        s_valid = 1;
        repeat (8) begin rnd_pix(); step(); end

        // Abort after two of eight, then a one-pixel frame.
        go_idle();
        s_valid = 1; m_ready = 1; rnd_pix();
        begin_frame(8);
        step(); step();
        abort = 1;
        step();
        abort = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_m_valid", 32'(m_valid), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", 32'(frame_done), 0);
        end
        begin_frame(1);
        step();
        chk("one_valid", 32'(m_valid), 1);
        chk("one_last", 32'(m_last), 1);
        s_valid = 0;
        step();
        chk("one_done", 32'(frame_done), 1);
        step();

        // Asynchronous reset in the middle of a frame.
        go_idle();
        s_valid = 1; m_ready = 1; rnd_pix();
        begin_frame(6);
        step(); step();
        #2 i_rst = 0;
        #1;
        model_reset();
        chk("arst_busy", 32'(busy), 0);
        chk("arst_m_valid", 32'(m_valid), 0);
        chk("arst_s_ready", 32'(s_ready), 0);
        chk("arst_dp_er", 32'(dp_er), 0);
        chk("arst_dp_ar", 32'(dp_ar), 0);
        compare_all();
        step();
        i_rst = 1;
        repeat (3) step();
        chk("arst_no_done", 32'(frame_done), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom % 6 == 0);
            cfg_npix = 20'($urandom_range(0, 6));
            cfg_ar = 8'($urandom); cfg_ag = 8'($urandom); cfg_ab = 8'($urandom);
            abort   = ($urandom % 90 == 0);
            s_valid = ($urandom % 4 != 0);
            m_ready = ($urandom % 3 != 0);
            rnd_pix();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
